regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Debug reader that sits on one read port of the 32x32 register file: re, raddr and rdata attach to the re2/raddr2/rdata2 port through a debug mux.
- On a start request it walks a range of register addresses, reads each one, and serializes it as a byte stream with valid/ready handshake toward the debug UART/JTAG bridge.
- Each dump is framed by a header byte so that host software can resynchronize.

Parameters:
REG_NUM, 32, number of architectural registers
REG_ADDR_W, 5, register address width (log2 REG_NUM)
DATA_W, 32, register width; must be a multiple of 8
HDR_BYTE, 8'hA5, frame header byte sent before each dump

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  dump request; sampled only in IDLE
first_addr  in  REG_ADDR_W  first register to dump, latched on accepted start
last_addr  in  REG_ADDR_W  last register to dump, latched on accepted start
busy  out  1  high from the cycle after an accepted start until DONE exits
done  out  1  one-cycle pulse when the dump completes
re  out  1  read enable to the regfile read port
raddr  out  REG_ADDR_W  read address to the regfile read port
rdata  in  DATA_W  combinational read data from the regfile port
byte_valid  out  1  byte_data is valid
byte_ready  in  1  sink accepts the byte when valid and ready are both high
byte_data  out  8  stream byte
byte_last  out  1  marks the final byte of the dump

Behaviour:
- Reset values: busy=0, done=0, re=0, raddr=0, byte_valid=0, byte_data=0, byte_last=0. FSM goes to IDLE. Reset has priority over everything, including mid-dump; any partial frame is abandoned with no done pulse.
- States: IDLE, HDR, READ, SEND, DONE.
- IDLE:
  - re=0, raddr=0.
  - start=1 → latch first_addr/last_addr, set cur=first_addr, go to HDR.
- HDR:
  - byte_valid=1, byte_data=HDR_BYTE.
  - byte_last=1 only if first_addr > last_addr (empty range).
  - On handshake: go to DONE if the range is empty, else go to READ.
- READ (exactly one cycle):
  - re=1, raddr=cur.
  - At the clock edge, capture rdata into a DATA_W shift register and clear the byte counter.
  - Go to SEND.
  - Whatever the port presents is captured, including a same-cycle write-forwarded value; reading address 0 returns 0.
- SEND:
  - re=0; raddr holds cur.
  - byte_valid=1, byte_data=shift[7:0]. Byte order is LSB first (little-endian); DATA_W/8 bytes per register.
  - byte_data and byte_last must stay stable while byte_valid=1 and byte_ready=0.
  - On handshake: shift right by 8 and increment the byte counter.
  - After the final byte of a register: go to DONE if cur==last_addr, else cur=cur+1 and go to READ.
  - byte_last=1 only on the final byte of register last_addr.
- DONE: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
- busy=1 in HDR, READ, SEND and DONE.
- start outside IDLE is ignored; first_addr/last_addr changes after latching are ignored.
- Address wrap: cur never increments past last_addr, so cur cannot wrap. last_addr=REG_NUM-1 is legal.
- Latency: start at cycle N → header valid at N+1. A header handshake at cycle M → READ at M+1, first data byte valid at M+2.
- With byte_ready tied high, throughput is DATA_W/8+1 cycles per register.
- Handshake combinational paths: no combinational path from byte_ready to byte_valid or byte_data; all stream outputs are registered or decoded from state only.

Decomposition:
- Shared defines file:
  - RstEnable / ReadEnable polarity constants
  - RegAddrBus / RegBus widths
  - state encodings DUMP_IDLE, DUMP_HDR, DUMP_READ, DUMP_SEND, DUMP_DONE
  - DumpHdrByte
- One natural sub-module, dump_byte_serializer: DATA_W load, 8-bit shift, byte counter, last-byte flag, valid/ready hold logic.
- The top level keeps the FSM and address counter.

Test Plan:
- Regfile model with r3=32'h11223344; start, first=3, last=3, byte_ready=1 → bytes A5,44,33,22,11; byte_last on 11; one done pulse; re high exactly one cycle with raddr=3.
- Range 0..1 with r1=32'hDEADBEEF → A5,00,00,00,00,EF,BE,AD,DE; byte_last only on DE.
- Random byte_ready backpressure over range 1..31 → every byte matches its register value; byte_data/byte_last stable while stalled; 1+31*4=125 bytes total.
- first=5, last=2 → single byte A5 with byte_last=1, then done; re never asserted.
- start pulsed again mid-dump → ignored, stream unchanged; assert rst during SEND → next cycle busy=0, byte_valid=0, re=0, no done; new start then produces a full frame.
- Writeback writes r4=32'hCAFEF00D in the same cycle as READ of r4 (forwarding port) → stream carries 0D,F0,FE,CA.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants and state encoding for the register-file dump reader.
package regfile_dump_reader_pkg;

   localparam logic       RstEnable   = 1'b1;
   localparam logic       ReadEnable  = 1'b1;
   localparam int         RegAddrBus  = 5;
   localparam int         RegBus      = 32;
   localparam logic [7:0] DumpHdrByte = 8'hA5;

   typedef enum logic [2:0] {
      DUMP_IDLE,
      DUMP_HDR,
      DUMP_READ,
      DUMP_SEND,
      DUMP_DONE
   } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader_serializer.sv
// Turns one captured register word into a little-endian byte sequence,
// advancing only when the sink accepts the current byte.
module dump_byte_serializer
   import regfile_dump_reader_pkg::*;
#(
   parameter int DATA_W = RegBus
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   input  logic              ready_i,
   output logic [7:0]        byte_o,
   output logic              last_byte_o,
   output logic              fire_o
);

   localparam int NB    = DATA_W / 8;
   localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign fire_o      = valid_i & ready_i;
   assign byte_o      = shift_q[7:0];
   assign last_byte_o = (cnt_q == CNT_W'(NB - 1));

   // Contents only move on an accepted byte, so the presented byte holds under backpressure.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         shift_d = data_i;
         cnt_d   = '0;
      end else if (fire_o) begin
         shift_d = shift_q >> 8;
         cnt_d   = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      if (rst == RstEnable) cnt_q <= '0;
      else                  cnt_q <= cnt_d;
   end

endmodule

// File: rtl/regfile_dump_reader.sv
// Debug reader: walks a register range on a spare regfile read port and
// streams a header byte followed by each register, LSB first.
module regfile_dump_reader
   import regfile_dump_reader_pkg::*;
#(
   parameter int         REG_NUM    = 32,
   parameter int         REG_ADDR_W = $clog2(REG_NUM),
   parameter int         DATA_W     = RegBus,
   parameter logic [7:0] HDR_BYTE   = DumpHdrByte
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [REG_ADDR_W-1:0] first_addr,
   input  logic [REG_ADDR_W-1:0] last_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  re,
   output logic [REG_ADDR_W-1:0] raddr,
   input  logic [DATA_W-1:0]     rdata,
   output logic                  byte_valid,
   input  logic                  byte_ready,
   output logic [7:0]            byte_data,
   output logic                  byte_last
);

   dump_state_e           state_q, state_d;
   logic [REG_ADDR_W-1:0] cur_q, cur_d;
   logic [REG_ADDR_W-1:0] last_q, last_d;
   logic                  empty_q, empty_d;

   logic [7:0] ser_byte;
   logic       ser_last;
   logic       ser_fire;
   logic       send_st;

   assign send_st = (state_q == DUMP_SEND);

   dump_byte_serializer #(.DATA_W(DATA_W)) u_ser (
      .clk        (clk),
      .rst        (rst),
      .load_i     (state_q == DUMP_READ),
      .data_i     (rdata),
      .valid_i    (send_st),
      .ready_i    (byte_ready),
      .byte_o     (ser_byte),
      .last_byte_o(ser_last),
      .fire_o     (ser_fire)
   );

   // Stream outputs decode from state and registers only; byte_ready steers next state, never outputs.
   always_comb begin
      busy       = (state_q != DUMP_IDLE);
      done       = (state_q == DUMP_DONE);
      re         = (state_q == DUMP_READ) ? ReadEnable : ~ReadEnable;
      raddr      = (state_q == DUMP_IDLE) ? '0 : cur_q;
      byte_valid = (state_q == DUMP_HDR) || send_st;
      byte_data  = 8'h00;
      byte_last  = 1'b0;
      if (state_q == DUMP_HDR) begin
         byte_data = HDR_BYTE;
         byte_last = empty_q;
      end else if (send_st) begin
         byte_data = ser_byte;
         byte_last = ser_last && (cur_q == last_q);
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      last_d  = last_q;
      empty_d = empty_q;
      unique case (state_q)
         DUMP_IDLE: if (start) begin
            cur_d   = first_addr;
            last_d  = last_addr;
            empty_d = (first_addr > last_addr);
            state_d = DUMP_HDR;
         end
         DUMP_HDR: if (byte_ready) state_d = empty_q ? DUMP_DONE : DUMP_READ;
         DUMP_READ: state_d = DUMP_SEND;
         DUMP_SEND: if (ser_fire && ser_last) begin
            if (cur_q == last_q) begin
               state_d = DUMP_DONE;
            end else begin
               cur_d   = cur_q + 1'b1;
               state_d = DUMP_READ;
            end
         end
         DUMP_DONE: state_d = DUMP_IDLE;
         default:   state_d = DUMP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) state_q <= DUMP_IDLE;
      else                  state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      empty_q <= empty_d;
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader against a queue-based frame model.
module tb_regfile_dump_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  first_addr, last_addr;
   logic        busy, done, re;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic        byte_valid, byte_ready;
   logic [7:0]  byte_data;
   logic        byte_last;

   logic [31:0] regs [32];
   logic        fwd_en = 1'b0;
   logic        wb_we;
   logic [31:0] wb_data = 32'hCAFEF00D;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] exp_d [$];
   logic       exp_l [$];
   int  dump_first = 0;
   int  re_cnt = 0, done_cnt = 0, hs_cnt = 0;
   bit  mon_en = 1'b1;
   bit  rnd_ready = 1'b0;
   logic       prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
   logic [7:0] prev_d = 8'h00;

   always #5 clk = ~clk;

   // Regfile read port with same-cycle write forwarding of r4; r0 reads as zero.
   assign wb_we = fwd_en && re && (raddr == 5'd4);
   assign rdata = (raddr == 5'd0) ? 32'h0 : (wb_we ? wb_data : regs[raddr]);

   regfile_dump_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .first_addr(first_addr),
      .last_addr (last_addr),
      .busy      (busy),
      .done      (done),
      .re        (re),
      .raddr     (raddr),
      .rdata     (rdata),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .byte_data (byte_data),
      .byte_last (byte_last)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      byte_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         byte_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_v && !prev_r) begin
            check("hold_valid", byte_valid, 1);
            check("hold_data", byte_data, prev_d);
            check("hold_last", byte_last, prev_l);
         end
         if (byte_valid && byte_ready) begin
            hs_cnt++;
            if (exp_d.size() == 0) check("extra_byte", 1, 0);
            else begin
               check("byte_data", byte_data, exp_d.pop_front());
               check("byte_last", byte_last, exp_l.pop_front());
            end
         end
         if (re) begin
            check("raddr", raddr, dump_first + re_cnt);
            re_cnt++;
         end
         if (done) done_cnt++;
      end
      prev_v = byte_valid;
      prev_r = byte_ready;
      prev_d = byte_data;
      prev_l = byte_last;
   end

   task automatic build_frame(input int f, input int l, input bit fwd);
      logic [31:0] val;
      exp_d.delete();
      exp_l.delete();
      exp_d.push_back(8'hA5);
      exp_l.push_back(f > l);
      for (int a = f; a <= l; a++) begin
         if (a == 0)             val = 32'h0;
         else if (fwd && a == 4) val = wb_data;
         else                    val = regs[a];
         for (int b = 0; b < 4; b++) begin
            exp_d.push_back(val[8*b +: 8]);
            exp_l.push_back((a == l) && (b == 3));
         end
      end
   endtask

   task automatic run_dump(input int f, input int l, input bit rnd, input bit mid, input bit fwd);
      int nbytes;
      bit got;
      build_frame(f, l, fwd);
      nbytes     = exp_d.size();
      dump_first = f;
      re_cnt     = 0;
      done_cnt   = 0;
      hs_cnt     = 0;
      fwd_en     = fwd;
      rnd_ready  = rnd;
      @(posedge clk);
      #1;
      first_addr = 5'(f);
      last_addr  = 5'(l);
      start      = 1'b1;
      @(posedge clk);
      #2;
      start      = 1'b0;
      first_addr = 5'($urandom_range(0, 31));
      last_addr  = 5'($urandom_range(0, 31));
      check("hdr_valid", byte_valid, 1);
      check("hdr_byte", byte_data, 8'hA5);
      check("busy_on", busy, 1);
      got = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         if (mid && c == 4) begin
            start      = 1'b1;
            first_addr = 5'd7;
            last_addr  = 5'd9;
         end
         if (mid && c == 5) start = 1'b0;
         @(posedge clk);
         #2;
      end
      check("done_seen", got, 1);
      repeat (3) @(posedge clk);
      #2;
      check("done_pulses", done_cnt, 1);
      check("busy_idle", busy, 0);
      check("bytes_left", exp_d.size(), 0);
      check("byte_count", hs_cnt, nbytes);
      check("re_cycles", re_cnt, (f > l) ? 0 : (l - f + 1));
      rnd_ready = 1'b0;
      fwd_en    = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      first_addr = 5'd0;
      last_addr  = 5'd0;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      regs[0] = 32'h5555AAAA;
      regs[1] = 32'hDEADBEEF;
      regs[3] = 32'h11223344;
      repeat (3) @(posedge clk);
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_re", re, 0);
      check("rst_raddr", raddr, 0);
      check("rst_valid", byte_valid, 0);
      check("rst_data", byte_data, 0);
      check("rst_last", byte_last, 0);
      rst = 1'b0;

      run_dump(3, 3, 1'b0, 1'b0, 1'b0);
      run_dump(0, 1, 1'b0, 1'b0, 1'b0);
      run_dump(1, 31, 1'b1, 1'b0, 1'b0);
      check("full_range_bytes", hs_cnt, 125);
      run_dump(5, 2, 1'b0, 1'b0, 1'b0);
      run_dump(2, 6, 1'b1, 1'b1, 1'b0);

      // Abort a dump mid-register with reset; no done pulse may follow.
      mon_en = 1'b0;
      @(posedge clk);
      #1;
      first_addr = 5'd3;
      last_addr  = 5'd3;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("pre_rst_send", byte_valid && !re && byte_data == 8'h44, 1);
      rst = 1'b1;
      @(posedge clk);
      #2;
      check("abort_busy", busy, 0);
      check("abort_valid", byte_valid, 0);
      check("abort_re", re, 0);
      check("abort_done", done, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("abort_no_done", done, 0);
      mon_en = 1'b1;
      run_dump(3, 3, 1'b0, 1'b0, 1'b0);

      regs[4] = 32'h0;
      run_dump(4, 4, 1'b0, 1'b0, 1'b1);
      regs[4] = wb_data;

      run_dump(0, 31, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
